// File: rtl/group_sum_out_fifo.sv
// group_sum_out_fifo
// Output buffer for the group accumulator. Each incoming group sum is
// tagged with its position inside the output frame and queued in a small
// circular buffer. The head entry is presented first-word-fall-through
// from dedicated output registers, so the downstream sees stable data and
// flags without a read-address path in front of the outputs.
// The upstream cannot be stalled: a word arriving into a full buffer with
// no pop in the same cycle is dropped and recorded in a sticky flag. The
// frame index still advances for dropped words, so later frames keep
// their alignment.

module group_sum_out_fifo #(
  parameter int DW               = 16,
  parameter int H_TILE           = 1,
  parameter int P_TILE           = 1,
  parameter int DEPTH            = 4,
  parameter int GROUPS_PER_FRAME = 8,
  localparam int HPW             = H_TILE * P_TILE * DW,
  localparam int IDXW            = (GROUPS_PER_FRAME > 1) ? $clog2(GROUPS_PER_FRAME) : 1,
  localparam int AW              = $clog2(DEPTH),
  localparam int LW              = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [HPW-1:0]  group_sum_i,
  output logic            m_valid_o,
  input  logic            m_ready_i,
  output logic [HPW-1:0]  m_data_o,
  output logic [IDXW-1:0] m_idx_o,
  output logic            m_last_o,
  output logic [LW-1:0]   level_o,
  output logic            overflow_o,
  input  logic            clear_ovf_i
);

  localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(GROUPS_PER_FRAME - 1);
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0]   ONE_LEVEL  = LW'(1);

  // Entry storage; contents are never cleared, only the pointers and
  // occupancy decide what is valid.
  logic [HPW-1:0]  data_mem [DEPTH];
  logic [IDXW-1:0] idx_mem  [DEPTH];

  // Pointers, occupancy and frame position.
  logic [AW-1:0]   head_reg,      head_next;
  logic [AW-1:0]   tail_reg,      tail_next;
  logic [LW-1:0]   level_reg,     level_next;
  logic [IDXW-1:0] frame_idx_reg, frame_idx_next;
  logic            overflow_reg,  overflow_next;

  // Registered copy of the head entry, driven straight to the outputs.
  logic [HPW-1:0]  out_data_reg,  out_data_next;
  logic [IDXW-1:0] out_idx_reg,   out_idx_next;
  logic            out_last_reg,  out_last_next;

  logic            push;
  logic            pop;
  logic            drop;
  logic [AW-1:0]   head_plus_one;

  // Transfer qualification. A pop frees a slot in the same cycle, so a
  // full buffer still accepts a word when the head is being taken.
  always_comb begin
    pop           = (level_reg != '0) && m_ready_i;
    push          = valid_i && ((level_reg < FULL_LEVEL) || pop);
    drop          = valid_i && !push;
    head_plus_one = head_reg + 1'b1;
  end

  // Pointer, occupancy, frame index and sticky overflow next-state.
  always_comb begin
    head_next      = head_reg;
    tail_next      = tail_reg;
    level_next     = level_reg;
    frame_idx_next = frame_idx_reg;
    overflow_next  = overflow_reg;

    if (pop) begin
      head_next = head_plus_one;
    end
    if (push) begin
      tail_next = tail_reg + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_next = level_reg + ONE_LEVEL;
      2'b01:   level_next = level_reg - ONE_LEVEL;
      default: level_next = level_reg;
    endcase

    // Every arriving word occupies a frame slot, whether or not it is kept.
    if (valid_i) begin
      frame_idx_next = (frame_idx_reg == LAST_IDX) ? '0 : frame_idx_reg + 1'b1;
    end

    // A new drop takes precedence over a clear in the same cycle.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clear_ovf_i) begin
      overflow_next = 1'b0;
    end
  end

  // Next head entry for the output registers. After a pop the new head is
  // either the word arriving this cycle (buffer held only one entry) or
  // the next stored entry. An empty buffer presents zeros.
  always_comb begin
    out_data_next = out_data_reg;
    out_idx_next  = out_idx_reg;
    out_last_next = 1'b0;

    if (level_next == '0) begin
      out_data_next = '0;
      out_idx_next  = '0;
    end else if (pop) begin
      if (level_reg == ONE_LEVEL) begin
        out_data_next = group_sum_i;
        out_idx_next  = frame_idx_reg;
      end else begin
        out_data_next = data_mem[head_plus_one];
        out_idx_next  = idx_mem[head_plus_one];
      end
    end else if (level_reg == '0) begin
      out_data_next = group_sum_i;
      out_idx_next  = frame_idx_reg;
    end

    if (level_next != '0) begin
      out_last_next = (out_idx_next == LAST_IDX);
    end
  end

  // Write the arriving word and its frame tag at the tail slot.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      data_mem[tail_reg] <= group_sum_i;
      idx_mem[tail_reg]  <= frame_idx_reg;
    end
  end

  // Control state; reset discards everything in flight and ignores valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      level_reg     <= '0;
      frame_idx_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      level_reg     <= level_next;
      frame_idx_reg <= frame_idx_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Head-entry output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg <= '0;
      out_idx_reg  <= '0;
      out_last_reg <= 1'b0;
    end else begin
      out_data_reg <= out_data_next;
      out_idx_reg  <= out_idx_next;
      out_last_reg <= out_last_next;
    end
  end

  assign m_valid_o  = (level_reg != '0);
  assign m_data_o   = out_data_reg;
  assign m_idx_o    = out_idx_reg;
  assign m_last_o   = out_last_reg;
  assign level_o    = level_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_group_sum_out_fifo.sv
// Directed bench for group_sum_out_fifo with a scoreboard queue: the
// stimulus pushes each expected {idx, data} when it drives a word that
// should be kept, and a negedge monitor pops and compares on each transfer.

module tb_group_sum_out_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [15:0] group_sum_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [15:0] m_data_o;
  logic [2:0]  m_idx_o;
  logic        m_last_o;
  logic [2:0]  level_o;
  logic        overflow_o;
  logic        clear_ovf_i;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int tb_idx = 0;

  typedef struct packed {
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];

  group_sum_out_fifo #(
    .DW(16), .H_TILE(1), .P_TILE(1), .DEPTH(4), .GROUPS_PER_FRAME(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .group_sum_i (group_sum_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_idx_o     (m_idx_o),
    .m_last_o    (m_last_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .clear_ovf_i (clear_ovf_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one valid_i word for one cycle; record it when it should be kept.
  task automatic send(input logic [15:0] d, input bit keep);
    exp_t e;
    valid_i     = 1'b1;
    group_sum_i = d;
    if (keep) begin
      e.idx  = 3'(tb_idx);
      e.data = d;
      sb_q.push_back(e);
    end
    tb_idx = (tb_idx + 1) % 8;
    cyc();
    valid_i = 1'b0;
  endtask

  // Reset for two cycles with valid_i held high (must be ignored).
  task automatic do_reset();
    rst         = 1'b1;
    valid_i     = 1'b1;
    group_sum_i = 16'hDEAD;
    m_ready_i   = 1'b0;
    clear_ovf_i = 1'b0;
    sb_q.delete();
    tb_idx = 0;
    cyc();
    cyc();
    rst     = 1'b0;
    valid_i = 1'b0;
  endtask

  // Transfer monitor: each accepted word must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid_o && m_ready_i) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_xfer", {16'h0, m_data_o}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        $display("xfer data=%04h idx=%0d last=%0d", m_data_o, m_idx_o, m_last_o);
        chk("xfer_data", {16'h0, m_data_o}, {16'h0, e.data});
        chk("xfer_idx",  {29'h0, m_idx_o},  {29'h0, e.idx});
        chk("xfer_last", {31'h0, m_last_o}, {31'h0, (e.idx == 3'd7)});
        xfers++;
      end
    end
  end

  initial begin
    int base;
    rst = 1'b0; valid_i = 1'b0; group_sum_i = '0; m_ready_i = 1'b0; clear_ovf_i = 1'b0;

    // Reset state.
    do_reset();
    chk("rst_level", {29'h0, level_o},   0);
    chk("rst_valid", {31'h0, m_valid_o}, 0);
    chk("rst_last",  {31'h0, m_last_o},  0);
    chk("rst_idx",   {29'h0, m_idx_o},   0);
    chk("rst_data",  {16'h0, m_data_o},  0);
    chk("rst_ovf",   {31'h0, overflow_o}, 0);

    // Single word, one-cycle latency, drained by ready.
    m_ready_i = 1'b1;
    send(16'h3C00, 1'b1);
    chk("single_valid", {31'h0, m_valid_o}, 1);
    chk("single_data",  {16'h0, m_data_o},  32'h3C00);
    chk("single_idx",   {29'h0, m_idx_o},   0);
    chk("single_last",  {31'h0, m_last_o},  0);
    chk("single_level", {29'h0, level_o},   1);
    cyc();
    chk("single_drain_level", {29'h0, level_o},  0);
    chk("single_drain_valid", {31'h0, m_valid_o}, 0);
    chk("empty_data_zero",    {16'h0, m_data_o},  0);

    // 16 back-to-back words with ready high: two full frames.
    do_reset();
    m_ready_i = 1'b1;
    base = xfers;
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b1);
    repeat (3) cyc();
    chk("b2b_xfers", 32'(xfers - base), 16);
    chk("b2b_ovf",   {31'h0, overflow_o}, 0);
    chk("b2b_sb_empty", 32'(sb_q.size()), 0);

    // Overfill with ready low: 4 kept, 2 dropped, head held stable.
    do_reset();
    m_ready_i = 1'b0;
    for (int i = 1; i <= 6; i++) send(16'(i), i <= 4);
    chk("full_level", {29'h0, level_o},   4);
    chk("full_ovf",   {31'h0, overflow_o}, 1);
    chk("hold_data",  {16'h0, m_data_o},  1);
    chk("hold_idx",   {29'h0, m_idx_o},   0);
    m_ready_i = 1'b1;
    repeat (4) cyc();
    chk("full_drained", {29'h0, level_o}, 0);
    send(16'd7, 1'b1);
    chk("after_drop_idx", {29'h0, m_idx_o}, 6);
    cyc();
    chk("after_drop_sb_empty", 32'(sb_q.size()), 0);

    // Clear alone.
    clear_ovf_i = 1'b1;
    cyc();
    clear_ovf_i = 1'b0;
    chk("clear_alone", {31'h0, overflow_o}, 0);

    // Continuous push/pop at full level across pointer wraps.
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h100 + 16'(i), 1'b1);
    chk("pp_fill_level", {29'h0, level_o}, 4);
    m_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(16'h200 + 16'(i), 1'b1);
      chk("pp_level", {29'h0, level_o}, 4);
    end
    chk("pp_ovf", {31'h0, overflow_o}, 0);
    repeat (5) cyc();
    chk("pp_drained", {29'h0, level_o}, 0);
    chk("pp_sb_empty", 32'(sb_q.size()), 0);

    // Set wins over a coincident clear.
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h300 + 16'(i), 1'b1);
    send(16'h3FF, 1'b0);
    chk("drop_ovf", {31'h0, overflow_o}, 1);
    clear_ovf_i = 1'b1;
    cyc();
    clear_ovf_i = 1'b0;
    chk("clear_pulse", {31'h0, overflow_o}, 0);
    clear_ovf_i = 1'b1;
    send(16'h3FE, 1'b0);
    clear_ovf_i = 1'b0;
    chk("clear_vs_drop", {31'h0, overflow_o}, 1);
    chk("drop_level",    {29'h0, level_o}, 4);

    // Reset with three words in flight and valid_i high.
    m_ready_i = 1'b1;
    cyc();
    m_ready_i = 1'b0;
    chk("pre_rst_level", {29'h0, level_o}, 3);
    rst = 1'b1;
    valid_i = 1'b1;
    group_sum_i = 16'h5555;
    cyc();
    rst = 1'b0;
    valid_i = 1'b0;
    sb_q.delete();
    tb_idx = 0;
    chk("mid_rst_level", {29'h0, level_o},   0);
    chk("mid_rst_valid", {31'h0, m_valid_o}, 0);
    chk("mid_rst_ovf",   {31'h0, overflow_o}, 0);
    m_ready_i = 1'b1;
    send(16'hABCD, 1'b1);
    chk("post_rst_idx",  {29'h0, m_idx_o},  0);
    chk("post_rst_data", {16'h0, m_data_o}, 32'hABCD);
    cyc();
    chk("post_rst_sb_empty", 32'(sb_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
